// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled UART receiver (8N1, optional parity) with one-cycle strobe output
//
// Ports:
//   clk_50m        system clock, sole clock of the block
//   rst_n          asynchronous active-low reset, released synchronously upstream
//   baud16         16x baud square wave, sampled as data (never used as a clock)
//   rx_in          asynchronous serial line, idle high
//   rx_data        last received data word, LSB received first
//   rx_valid       one-cycle strobe: rx_data and error flags updated
//   rx_frame_err   stop bit sampled low in the last frame
//   rx_parity_err  parity mismatch in the last frame (0 when PARITY = 0)
//   rx_busy        high while a frame is in progress
//
// Parameters:
//   DATA_BITS      data bits per frame (5..8)
//   PARITY         0 = none, 1 = odd, 2 = even
module uart_rx_os16 #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 baud16,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int            IW   = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK
    } state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s;
    logic                 b_m, b_s, b_d;
    logic                 tick;
    logic [3:0]           os_cnt, os_n;
    logic [IW-1:0]        bit_idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 par_bit, par_n;
    logic                 strobe;
    logic                 pe;

    // b_d delays the synchronized baud wave so its rising edge yields a one-cycle tick
    assign tick    = b_s & ~b_d;
    assign rx_busy = state != S_IDLE;

    // With odd parity the data plus parity bit must hold an odd number of ones
    assign pe = PARITY == 1 ? ~(^sh ^ par_bit) :
                PARITY == 2 ?  (^sh ^ par_bit) : 1'b0;

    always_comb begin
        state_n = state;
        os_n    = os_cnt;
        idx_n   = bit_idx;
        sh_n    = sh;
        par_n   = par_bit;
        strobe  = 1'b0;
        if (tick) begin
            os_n = os_cnt + 4'd1;
            case (state)
                S_IDLE: begin
                    os_n = 4'd0;
                    if (!rx_s) state_n = S_START;
                end
                S_START: if (os_cnt == 4'd7) begin
                    os_n    = 4'd0;
                    idx_n   = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: if (os_cnt == 4'd15) begin
                    sh_n[bit_idx] = rx_s;
                    idx_n         = bit_idx + 1'b1;
                    if (bit_idx == LAST) state_n = PARITY != 0 ? S_PAR : S_STOP;
                end
                S_PAR: if (os_cnt == 4'd15) begin
                    par_n   = rx_s;
                    state_n = S_STOP;
                end
                S_STOP: if (os_cnt == 4'd15) begin
                    strobe  = 1'b1;
                    state_n = rx_s ? S_IDLE : S_BRK;
                end
                S_BRK: begin
                    os_n = 4'd0;
                    if (rx_s) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            b_m           <= 1'b0;
            b_s           <= 1'b0;
            b_d           <= 1'b0;
            state         <= S_IDLE;
            os_cnt        <= 4'd0;
            bit_idx       <= '0;
            sh            <= '0;
            par_bit       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_m     <= rx_in;
            rx_s     <= rx_m;
            b_m      <= baud16;
            b_s      <= b_m;
            b_d      <= b_s;
            state    <= state_n;
            os_cnt   <= os_n;
            bit_idx  <= idx_n;
            sh       <= sh_n;
            par_bit  <= par_n;
            rx_valid <= strobe;
            if (strobe) begin
                rx_data       <= sh;
                rx_frame_err  <= ~rx_s;
                rx_parity_err <= pe;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: scoreboard bench for uart_rx_os16, no-parity and even-parity instances
module tb_uart_rx_os16;

    localparam int TICK = 120;
    localparam int BIT  = 16 * TICK;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk_50m, rst_n, baud16, rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, fe_a, pe_a, busy_a;
    logic       valid_b, fe_b, pe_b, busy_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_chk  = 0;
    int   n_pass = 0;

    uart_rx_os16 #(.DATA_BITS(8), .PARITY(0)) u_a (
        .clk_50m(clk_50m), .rst_n(rst_n), .baud16(baud16), .rx_in(rx_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_frame_err(fe_a),
        .rx_parity_err(pe_a), .rx_busy(busy_a)
    );

    uart_rx_os16 #(.DATA_BITS(8), .PARITY(2)) u_b (
        .clk_50m(clk_50m), .rst_n(rst_n), .baud16(baud16), .rx_in(rx_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_frame_err(fe_b),
        .rx_parity_err(pe_b), .rx_busy(busy_b)
    );

    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    initial begin
        baud16 = 1'b0;
        forever #(TICK / 2) baud16 = ~baud16;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit expired, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input bit ln, input logic v);
        if (ln) rx_b = v;
        else rx_a = v;
        #(BIT);
    endtask

    task automatic send(input bit ln, input logic [7:0] d, input bit has_par, input logic par,
                        input logic stop_v, input logic exp_pe);
        exp_t e;
        e = '{d: d, fe: ~stop_v, pe: exp_pe};
        if (ln) qb.push_back(e);
        else qa.push_back(e);
        drive(ln, 1'b0);
        for (int i = 0; i < 8; i++) drive(ln, d[i]);
        if (has_par) drive(ln, par);
        drive(ln, stop_v);
    endtask

    always @(negedge clk_50m) if (valid_a) begin
        if (qa.size() == 0) begin
            n_chk++;
            $display("FAIL a_strobe: got unexpected strobe data 0x%0h expected none", data_a);
        end else begin
            ea = qa.pop_front();
            chk("a_data", 32'(data_a), 32'(ea.d));
            chk("a_frame_err", 32'(fe_a), 32'(ea.fe));
            chk("a_parity_err", 32'(pe_a), 32'(ea.pe));
        end
    end

    always @(negedge clk_50m) if (valid_b) begin
        if (qb.size() == 0) begin
            n_chk++;
            $display("FAIL b_strobe: got unexpected strobe data 0x%0h expected none", data_b);
        end else begin
            eb = qb.pop_front();
            chk("b_data", 32'(data_b), 32'(eb.d));
            chk("b_frame_err", 32'(fe_b), 32'(eb.fe));
            chk("b_parity_err", 32'(pe_b), 32'(eb.pe));
        end
    end

    initial begin
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        #100;
        chk("rst_a_data", 32'(data_a), 32'h0);
        chk("rst_a_valid", 32'(valid_a), 32'h0);
        chk("rst_a_flags", 32'({fe_a, pe_a}), 32'h0);
        chk("rst_a_busy", 32'(busy_a), 32'h0);
        chk("rst_b_data", 32'(data_b), 32'h0);
        chk("rst_b_busy", 32'(busy_b), 32'h0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        #(2 * BIT);

        fork
            send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                #(5 * BIT);
                chk("a5_busy_mid", 32'(busy_a), 32'h1);
            end
        join
        #(BIT);
        chk("a5_busy_after", 32'(busy_a), 32'h0);

        rx_a = 1'b0;
        #(4 * TICK);
        rx_a = 1'b1;
        #(14 * TICK);
        chk("glitch_busy", 32'(busy_a), 32'h0);
        #(BIT);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        #(BIT);

        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        #(2 * BIT);
        chk("break_busy", 32'(busy_a), 32'h1);
        rx_a = 1'b1;
        #(2 * BIT);
        chk("break_exit_busy", 32'(busy_a), 32'h0);
        chk("break_hold_fe", 32'(fe_a), 32'h1);
        send(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        #(BIT);

        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        #(2 * BIT);
        chk("b2b_hold_data", 32'(data_a), 32'h81);

        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        rx_a = 1'b1;
        #(BIT / 2);
        chk("rst_mid_busy_before", 32'(busy_a), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy_a), 32'h0);
        chk("rst_mid_valid", 32'(valid_a), 32'h0);
        chk("rst_mid_data", 32'(data_a), 32'h0);
        chk("rst_mid_flags", 32'({fe_a, pe_a}), 32'h0);
        #(BIT / 2);
        @(negedge clk_50m);
        rst_n = 1'b1;
        #(2 * BIT);
        send(1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        #(BIT);

        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        #(BIT);
        send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        #(BIT);
        chk("par_hold_pe", 32'(pe_b), 32'h1);

        #(2 * BIT);
        chk("a_all_strobes_seen", 32'(qa.size()), 32'h0);
        chk("b_all_strobes_seen", 32'(qb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver for the uart_IIC datapath. Recovers 8N1 frames (optional parity) from the serial line using the 16x-oversampling baud square wave driven by the baud clock divider (clk_50m / 327 ≈ 16 × 9600).
- The square wave is sampled as data in the clk_50m domain, never used as a clock. Each received byte is delivered as a one-cycle strobe with error flags.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first (5..8 legal).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.

Ports:
- clk_50m  input  1  system clock, 50 MHz, sole clock.
- rst_n  input  1  asynchronous active-low reset.
- baud16  input  1  16x-oversample baud square wave from the baud divider, treated as data.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last received data word.
- rx_valid  output  1  one-cycle strobe: rx_data and error flags updated.
- rx_frame_err  output  1  stop bit sampled 0 in the last frame.
- rx_parity_err  output  1  parity mismatch in the last frame; always 0 when PARITY=0.
- rx_busy  output  1  high while a frame is in progress (state ≠ IDLE).

Behaviour:
- Reset (async assert, sync release), all values:
  - rx_data = 0, rx_valid = 0, both error flags = 0, rx_busy = 0.
  - Synchronizers: rx_in to 1, baud16 to 0.
  - State IDLE, counters 0.
- Input conditioning:
  - rx_in and baud16 each pass through a 2-FF synchronizer.
  - tick = 1 for one clk_50m cycle on the synchronized rising edge of baud16.
  - All state and counter activity below advances only on tick cycles.
- Counters:
  - os_cnt, 4-bit, counts ticks within a bit and wraps 15→0.
  - bit_idx counts data bits.
- State IDLE:
  - On a tick with rx_s = 0: go to START, os_cnt = 0.
- State START:
  - os_cnt increments each tick.
  - When os_cnt = 7 (mid start bit): if rx_s = 0, go to DATA with os_cnt = 0 and bit_idx = 0.
  - Otherwise it is a glitch: return to IDLE with no strobe.
- State DATA:
  - When os_cnt = 15: shift rx_s into the shift register at position bit_idx (LSB first), os_cnt = 0.
  - After bit DATA_BITS-1: go to PARITY if PARITY ≠ 0, else STOP.
- State PARITY:
  - When os_cnt = 15: capture the parity bit, then go to STOP.
- State STOP:
  - When os_cnt = 15 (mid stop bit), on the next clk_50m edge:
    - rx_valid = 1 for exactly one cycle.
    - rx_data = shift register.
    - rx_frame_err = ~rx_s.
    - rx_parity_err computed from the data bits and the captured parity bit.
  - If rx_s = 1: go to IDLE.
  - If rx_s = 0: go to BREAK.
- State BREAK:
  - Stay until a tick with rx_s = 1, then go to IDLE. No further strobes while rx_s stays low.
- Flag holding:
  - rx_data and both error flags hold between strobes.
  - They update only with rx_valid, even on error; a frame with errors still strobes.
- Latency: rx_valid rises 1 clk_50m cycle after the tick that samples the middle of the stop bit.
- Back-to-back frames:
  - A start edge immediately after the stop sample (same or next tick) is accepted.
  - IDLE is re-entered on the same tick as the stop sample.
- No handshake or buffering:
  - The consumer must take rx_data within one frame time.
  - A new strobe overwrites rx_data.
- Reset mid-frame: the partial frame is discarded, no strobe is issued, and the receiver resumes from IDLE.
- baud16 stopped: state freezes. No timeout.

Test Plan:
- Common setup: clk_50m 50 MHz; baud16 square wave, period 327 clk_50m, high 164 / low 163; 1 bit = 16 ticks.
- Frame 0xA5, 8N1 -> exactly one rx_valid pulse; rx_data = 0xA5; rx_frame_err = 0; rx_parity_err = 0; rx_busy high from the start edge to the stop sample.
- rx_in low pulse of 4 ticks in IDLE -> no rx_valid; rx_busy returns to 0 by tick 8; next frame 0x3C received correctly.
- Frame 0x55 with stop bit forced 0, line held low 3 bit times -> one rx_valid; rx_data = 0x55; rx_frame_err = 1; no further strobes until the line goes high; next frame 0x01 clears rx_frame_err.
- PARITY = 2 (even): frame 0x07 with parity bit 1 -> rx_parity_err = 0; same data with parity bit 0 -> rx_parity_err = 1.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three rx_valid pulses ~10 bit times apart, with matching data.
- rst_n asserted during data bit 3 of 0x99 -> all outputs reset immediately, no strobe; after release, frame 0x99 received correctly.
